irq_ctrl: RTL and testbench

- Interrupt scheduler in front of the machine-mode CSR file.
- Synchronises the raw timer, software and external interrupt lines, masks them with mstatus.MIE and mie, and picks one cause by fixed priority.
- Waits for a precise commit slot at the writeback stage, then issues a single-cycle trap request (cause code plus epc) to the CSR block.
- Holds a pipeline flush for a programmable number of cycles so that only one trap enters per event.

---
 rtl/irq_ctrl_pkg.sv | 48 ++++
 rtl/irq_ctrl_sync.sv | 33 +++
 rtl/irq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_irq_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// irq_ctrl_pkg
// Shared types and constants for the machine-mode interrupt scheduler:
//   - irq_state_t : scheduler FSM state encoding
//   - irq_take_t  : trap request payload (mcause code + epc)
//   - IRQ_CODE_*  : mcause[3:0] values for the three interrupt sources
//   - irq_prio_code() : fixed-priority cause selection
// ---------------------------------------------------------------------------
package irq_ctrl_pkg;

  localparam int unsigned PC_W   = 64;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned MIE_W  = 12;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CODE_W-1:0] IRQ_CODE_EXT = 4'd11;
  localparam logic [CODE_W-1:0] IRQ_CODE_SW  = 4'd3;
  localparam logic [CODE_W-1:0] IRQ_CODE_TM  = 4'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    TAKE  = 2'd2,
    FLUSH = 2'd3
  } irq_state_t;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [PC_W-1:0]   pc;
  } irq_take_t;

  // External > software > timer; returns 0 when nothing is enabled.
  function automatic logic [CODE_W-1:0] irq_prio_code(input logic en_ex,
                                                      input logic en_sw,
                                                      input logic en_tm);
    logic [CODE_W-1:0] code;
    code = '0;
    if (en_ex) begin
      code = IRQ_CODE_EXT;
    end else if (en_sw) begin
      code = IRQ_CODE_SW;
    end else if (en_tm) begin
      code = IRQ_CODE_TM;
    end
    return code;
  endfunction

endpackage

// File: rtl/irq_ctrl_sync.sv
// ---------------------------------------------------------------------------
// irq_sync
// N-stage single-bit synchroniser for an interrupt level that is
// asynchronous to clk.
// Ports:
//   clk   in  core clock
//   reset in  asynchronous active-high reset (clears every stage)
//   i_d   in  raw asynchronous level
//   o_q   out synchronised level, STAGES clocks behind i_d
// ---------------------------------------------------------------------------
module irq_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift chain; bit 0 is the metastability-exposed stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl
// Interrupt scheduler in front of the machine-mode CSR file. Synchronises
// the raw timer/software/external lines, masks them with mstatus.MIE and
// mie, picks one cause by fixed priority, waits for a precise commit slot
// in writeback and issues a one-cycle trap request, then holds a pipeline
// flush for FLUSH_CYCLES cycles.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   trint, swint, exint     raw interrupt levels (asynchronous)
//   mstatus_mie, mie[11:0]  global and per-source enables
//   wb_valid, wb_pc,        writeback-stage instruction status
//   wb_exception, wb_mret,
//   stall
//   take_valid              one-cycle trap request
//   take_code, take_pc      mcause[3:0] and epc of the trap
//   flush                   squash all stages at and before W
//   busy                    scheduler is not idle
// ---------------------------------------------------------------------------
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trint,
  input  logic              swint,
  input  logic              exint,
  input  logic              mstatus_mie,
  input  logic [MIE_W-1:0]  mie,
  input  logic              wb_valid,
  input  logic [PC_W-1:0]   wb_pc,
  input  logic              wb_exception,
  input  logic              wb_mret,
  input  logic              stall,
  output logic              take_valid,
  output logic [CODE_W-1:0] take_code,
  output logic [PC_W-1:0]   take_pc,
  output logic              flush,
  output logic              busy
);

  logic w_s_ex;
  logic w_s_sw;
  logic w_s_tm;
  logic w_en_ex;
  logic w_en_sw;
  logic w_en_tm;
  logic w_pend;
  logic w_slot;
  logic [CODE_W-1:0] w_code;
  logic w_unused_mie;

  irq_state_t       r_state;
  irq_state_t       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  logic      w_capture;
  logic      w_take_valid_nxt;
  logic      w_flush_nxt;
  logic      w_busy_nxt;
  irq_take_t w_take_nxt;

  logic      r_take_valid;
  logic      r_flush;
  logic      r_busy;
  irq_take_t r_take;

  // Per-line synchronisers.
  irq_sync #(.STAGES(SYNC_STAGES)) u_sync_ex (
    .clk   (clk),
    .reset (reset),
    .i_d   (exint),
    .o_q   (w_s_ex)
  );

  irq_sync #(.STAGES(SYNC_STAGES)) u_sync_sw (
    .clk   (clk),
    .reset (reset),
    .i_d   (swint),
    .o_q   (w_s_sw)
  );

  irq_sync #(.STAGES(SYNC_STAGES)) u_sync_tm (
    .clk   (clk),
    .reset (reset),
    .i_d   (trint),
    .o_q   (w_s_tm)
  );

  // Each source is enabled by either of its two mie bits.
  assign w_en_ex = w_s_ex & (mie[11] | mie[9]);
  assign w_en_sw = w_s_sw & (mie[3]  | mie[1]);
  assign w_en_tm = w_s_tm & (mie[7]  | mie[5]);
  assign w_pend  = mstatus_mie & (w_en_ex | w_en_sw | w_en_tm);
  assign w_code  = irq_prio_code(w_en_ex, w_en_sw, w_en_tm);

  // Remaining mie bits carry no interrupt source here.
  assign w_unused_mie = ^{mie[10], mie[8], mie[6], mie[4], mie[2], mie[0]};

  // A precise slot: a real, committing instruction that does not itself trap.
  assign w_slot = wb_valid & ~stall & (wb_pc != '0) & ~wb_exception & ~wb_mret;

  // State register; outputs are registered from the next-state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_take_valid <= 1'b0;
      r_flush      <= 1'b0;
      r_busy       <= 1'b0;
      r_take       <= '0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_cnt_next;
      r_take_valid <= w_take_valid_nxt;
      r_flush      <= w_flush_nxt;
      r_busy       <= w_busy_nxt;
      r_take       <= w_take_nxt;
    end
  end

  // Next-state and flush counter.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_pend) begin
          w_next_state = ARM;
        end
      end
      ARM: begin
        // Losing pend cancels; an exception or MRET simply denies the slot.
        if (!w_pend) begin
          w_next_state = IDLE;
        end else if (w_slot) begin
          w_next_state = TAKE;
        end
      end
      TAKE: begin
        w_next_state = FLUSH;
        w_cnt_next   = CNT_W'(FLUSH_CYCLES);
      end
      FLUSH: begin
        // Last flush cycle is the one holding count 1; stall does not pause it.
        if (r_cnt <= CNT_W'(1)) begin
          w_next_state = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_next_state = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Output decode for the coming state; trap payload latched on entry to TAKE.
  always_comb begin
    w_capture        = (r_state == ARM) & w_pend & w_slot;
    w_take_valid_nxt = (w_next_state == TAKE);
    w_flush_nxt      = (w_next_state == TAKE) | (w_next_state == FLUSH);
    w_busy_nxt       = (w_next_state != IDLE);
    w_take_nxt       = r_take;
    if (w_capture) begin
      w_take_nxt.code = w_code;
      w_take_nxt.pc   = wb_pc;
    end
  end

  assign take_valid = r_take_valid;
  assign take_code  = r_take.code;
  assign take_pc    = r_take.pc;
  assign flush      = r_flush;
  assign busy       = r_busy;

endmodule

// File: tb/tb_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_ctrl
// Self-checking bench for irq_ctrl with default parameters
// (SYNC_STAGES = 2, FLUSH_CYCLES = 2). Expected trap requests are queued
// when stimulus is applied and checked when take_valid fires.
// ---------------------------------------------------------------------------
module tb_irq_ctrl;

  typedef struct packed {
    logic [3:0]  code;
    logic [63:0] pc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        trint;
  logic        swint;
  logic        exint;
  logic        mstatus_mie;
  logic [11:0] mie;
  logic        wb_valid;
  logic [63:0] wb_pc;
  logic        wb_exception;
  logic        wb_mret;
  logic        stall;
  logic        take_valid;
  logic [3:0]  take_code;
  logic [63:0] take_pc;
  logic        flush;
  logic        busy;

  int   total;
  int   bad;
  int   n_takes;
  exp_t exp_q[$];
  exp_t mon_e;

  irq_ctrl #(.SYNC_STAGES(2), .FLUSH_CYCLES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .trint        (trint),
    .swint        (swint),
    .exint        (exint),
    .mstatus_mie  (mstatus_mie),
    .mie          (mie),
    .wb_valid     (wb_valid),
    .wb_pc        (wb_pc),
    .wb_exception (wb_exception),
    .wb_mret      (wb_mret),
    .stall        (stall),
    .take_valid   (take_valid),
    .take_code    (take_code),
    .take_pc      (take_pc),
    .flush        (flush),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every trap request must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && take_valid) begin
      n_takes++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_take code=%0d pc=%h", take_code, take_pc);
      end else begin
        mon_e = exp_q.pop_front();
        if (take_code !== mon_e.code) begin
          bad++;
          $display("FAIL take_code got=%0d exp=%0d", take_code, mon_e.code);
        end
        total++;
        if (take_pc !== mon_e.pc) begin
          bad++;
          $display("FAIL take_pc got=%h exp=%h", take_pc, mon_e.pc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_take(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (take_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic go_idle();
    bit ok;
    mstatus_mie  = 1'b0;
    trint        = 1'b0;
    swint        = 1'b0;
    exint        = 1'b0;
    wb_exception = 1'b0;
    wb_mret      = 1'b0;
    stall        = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL go_idle busy=%b exp=0", busy);
    end
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    trint = 1'b0; swint = 1'b0; exint = 1'b0;
    mstatus_mie = 1'b0; mie = '0;
    wb_valid = 1'b0; wb_pc = '0; wb_exception = 1'b0; wb_mret = 1'b0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (take_valid !== 1'b0) begin bad++; $display("FAIL rst_take_valid got=%b exp=0", take_valid); end
    total++; if (take_code !== 4'd0) begin bad++; $display("FAIL rst_take_code got=%0d exp=0", take_code); end
    total++; if (take_pc !== 64'd0) begin bad++; $display("FAIL rst_take_pc got=%h exp=0", take_pc); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL rst_flush got=%b exp=0", flush); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    reset = 1'b0;
    tick();
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy got=%b exp=0", busy); end
  endtask

  task automatic test_timer();
    int n0;
    n0 = n_takes;
    mstatus_mie = 1'b1;
    mie         = 12'h080;
    wb_valid    = 1'b1;
    wb_pc       = 64'h8000_0010;
    stall       = 1'b0;
    exp_q.push_back('{code: 4'd7, pc: 64'h8000_0010});
    trint = 1'b1;
    tick(); tick(); tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL tm_arm_busy got=%b exp=1", busy); end
    total++; if (take_valid !== 1'b0) begin bad++; $display("FAIL tm_arm_take got=%b exp=0", take_valid); end
    tick();
    total++; if (take_valid !== 1'b1) begin bad++; $display("FAIL tm_take_latency got=%b exp=1", take_valid); end
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL tm_take_flush got=%b exp=1", flush); end
    // CSR block clears MIE on the take; line changes now must not matter.
    mstatus_mie = 1'b0;
    trint = 1'b0;
    tick();
    total++; if (take_valid !== 1'b0) begin bad++; $display("FAIL tm_single_cycle got=%b exp=0", take_valid); end
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL tm_flush1 got=%b exp=1", flush); end
    tick();
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL tm_flush2 got=%b exp=1", flush); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL tm_flush2_busy got=%b exp=1", busy); end
    tick();
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL tm_flush_end got=%b exp=0", flush); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tm_busy_end got=%b exp=0", busy); end
    tick();
    total++; if (n_takes !== n0 + 1) begin bad++; $display("FAIL tm_take_count got=%0d exp=%0d", n_takes, n0 + 1); end
    go_idle();
  endtask

  task automatic test_priority();
    bit ok;
    mstatus_mie = 1'b1;
    mie         = 12'h888;
    wb_valid    = 1'b1;
    wb_pc       = 64'h8000_0020;
    exp_q.push_back('{code: 4'd11, pc: 64'h8000_0020});
    trint = 1'b1; swint = 1'b1; exint = 1'b1;
    wait_take(ok);
    total++; if (!ok) begin bad++; $display("FAIL prio_timeout take_valid=%b exp=1", take_valid); end
    go_idle();
  endtask

  task automatic test_cancel();
    bit ok;
    int n0;
    n0 = n_takes;
    mstatus_mie = 1'b1;
    mie         = 12'h008;
    wb_valid    = 1'b1;
    wb_pc       = 64'h8000_0030;
    stall       = 1'b1;
    swint       = 1'b1;
    wait_busy(ok);
    total++; if (!ok) begin bad++; $display("FAIL cancel_arm_timeout busy=%b exp=1", busy); end
    swint = 1'b0;
    mstatus_mie = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_idle busy=%b exp=0", busy); end
    stall = 1'b0;
    repeat (5) tick();
    total++; if (n_takes !== n0) begin bad++; $display("FAIL cancel_no_take got=%0d exp=%0d", n_takes, n0); end
    go_idle();
  endtask

  task automatic test_exception();
    bit ok;
    int n0;
    n0 = n_takes;
    mstatus_mie  = 1'b1;
    mie          = 12'h800;
    wb_valid     = 1'b1;
    wb_pc        = 64'h8000_0040;
    wb_exception = 1'b1;
    exint        = 1'b1;
    wait_busy(ok);
    total++; if (!ok) begin bad++; $display("FAIL exc_arm_timeout busy=%b exp=1", busy); end
    tick();
    total++; if (take_valid !== 1'b0) begin bad++; $display("FAIL exc_no_take got=%b exp=0", take_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL exc_stay_arm got=%b exp=1", busy); end
    mstatus_mie = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL exc_idle got=%b exp=0", busy); end
    total++; if (n_takes !== n0) begin bad++; $display("FAIL exc_take_count got=%0d exp=%0d", n_takes, n0); end
    go_idle();
  endtask

  task automatic test_slot_qual();
    bit ok;
    mstatus_mie = 1'b1;
    mie         = 12'h020;
    wb_valid    = 1'b1;
    wb_pc       = 64'd0;
    trint       = 1'b1;
    wait_busy(ok);
    total++; if (!ok) begin bad++; $display("FAIL slot_arm_timeout busy=%b exp=1", busy); end
    tick();
    total++; if (take_valid !== 1'b0) begin bad++; $display("FAIL slot_pc0 got=%b exp=0", take_valid); end
    wb_pc = 64'h8000_0100;
    stall = 1'b1;
    tick();
    total++; if (take_valid !== 1'b0) begin bad++; $display("FAIL slot_stall got=%b exp=0", take_valid); end
    stall = 1'b0;
    wb_mret = 1'b1;
    tick();
    total++; if (take_valid !== 1'b0) begin bad++; $display("FAIL slot_mret got=%b exp=0", take_valid); end
    wb_mret = 1'b0;
    wb_valid = 1'b0;
    tick();
    total++; if (take_valid !== 1'b0) begin bad++; $display("FAIL slot_novalid got=%b exp=0", take_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL slot_still_arm got=%b exp=1", busy); end
    wb_valid = 1'b1;
    exp_q.push_back('{code: 4'd7, pc: 64'h8000_0100});
    tick();
    total++; if (take_valid !== 1'b1) begin bad++; $display("FAIL slot_take got=%b exp=1", take_valid); end
    go_idle();
  endtask

  task automatic test_reset_flush();
    bit ok;
    mstatus_mie = 1'b1;
    mie         = 12'h080;
    wb_valid    = 1'b1;
    wb_pc       = 64'h8000_0200;
    exp_q.push_back('{code: 4'd7, pc: 64'h8000_0200});
    trint = 1'b1;
    wait_take(ok);
    total++; if (!ok) begin bad++; $display("FAIL rstfl_timeout take_valid=%b exp=1", take_valid); end
    mstatus_mie = 1'b0;
    trint = 1'b0;
    tick();
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL rstfl_in_flush got=%b exp=1", flush); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL rstfl_flush got=%b exp=0", flush); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstfl_busy got=%b exp=0", busy); end
    total++; if (take_valid !== 1'b0) begin bad++; $display("FAIL rstfl_take got=%b exp=0", take_valid); end
    tick();
    tick();
    reset = 1'b0;
    repeat (4) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstfl_after got=%b exp=0", busy); end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    n_takes = 0;
    test_reset();
    test_timer();
    test_priority();
    test_cancel();
    test_exception();
    test_slot_qual();
    test_reset_flush();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_takes left=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
